// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter and receiver.
package uart_pkg;

  localparam int DATA_BITS       = 8;
  localparam int CLK_PER_BIT_DEF = 434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 deserialiser with a two-flop input synchronizer and mid-bit sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  uart_state_e          state_r, state_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [BW-1:0]        bit_r, bit_s;
  logic [DATA_BITS-1:0] shreg_r, shreg_s;
  logic [DATA_BITS-1:0] data_r, data_s;
  logic                 done_r, done_s;
  logic                 armed_r, armed_s;
  logic [1:0]           sync_r;
  logic                 rx_s;

  assign rx_s = sync_r[1];

  // Synchronizer, FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r  <= 2'b11;
      state_r <= IDLE;
      cnt_r   <= CW'(0);
      bit_r   <= BW'(0);
      shreg_r <= DATA_BITS'(0);
      data_r  <= DATA_BITS'(0);
      done_r  <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[0], rx};
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shreg_r <= shreg_s;
      data_r  <= data_s;
      done_r  <= done_s;
      armed_r <= armed_s;
    end
  end

  // Next-state logic; armed_r blocks a new start until the line is seen high after a framing error
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    shreg_s = shreg_r;
    data_s  = data_r;
    done_s  = 1'b0;
    armed_s = armed_r;
    case (state_r)
      IDLE: begin
        cnt_s = CW'(0);
        bit_s = BW'(0);
        if (!rx_s && armed_r) begin
          state_s = START;
        end else if (rx_s) begin
          armed_s = 1'b1;
        end else begin
          armed_s = armed_r;
        end
      end
      START: begin
        if (cnt_r == HALF_M1) begin
          cnt_s = CW'(0);
          if (rx_s) begin
            state_s = IDLE;
          end else begin
            state_s = DATA;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s   = CW'(0);
          shreg_s = {rx_s, shreg_r[DATA_BITS-1:1]};
          if (bit_r == BIT_LAST) begin
            state_s = STOP;
          end else begin
            bit_s   = bit_r + BW'(1);
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s   = CW'(0);
          state_s = IDLE;
          if (rx_s) begin
            data_s = shreg_r;
            done_s = 1'b1;
          end else begin
            armed_s = 1'b0;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CW'(0);
      end
    endcase
  end

  assign rx_data = data_r;
  assign rx_done = done_r;

endmodule

// File: rtl/uart_tx.sv
// 8N1 serialiser: start bit, eight data bits LSB first, stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  uart_state_e          state_r, state_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [BW-1:0]        bit_r, bit_s;
  logic [DATA_BITS-1:0] shreg_r, shreg_s;
  logic                 tx_r, tx_s;
  logic                 busy_r, busy_s;

  // State, counters and registered line outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CW'(0);
      bit_r   <= BW'(0);
      shreg_r <= DATA_BITS'(0);
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shreg_r <= shreg_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
    end
  end

  // Next-state logic; line outputs are derived from the next state so they register with it
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    shreg_s = shreg_r;
    case (state_r)
      IDLE: begin
        if (tx_start) begin
          state_s = START;
          cnt_s   = CW'(0);
          shreg_s = tx_data;
        end else begin
          cnt_s   = CW'(0);
        end
      end
      START: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s   = CW'(0);
          bit_s   = BW'(0);
          state_s = DATA;
        end else begin
          cnt_s   = cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s   = CW'(0);
          shreg_s = {1'b0, shreg_r[DATA_BITS-1:1]};
          if (bit_r == BIT_LAST) begin
            state_s = STOP;
          end else begin
            bit_s   = bit_r + BW'(1);
          end
        end else begin
          cnt_s   = cnt_r + CW'(1);
        end
      end
      STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s   = CW'(0);
          state_s = IDLE;
        end else begin
          cnt_s   = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CW'(0);
      end
    endcase

    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shreg_s[0];
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
    busy_s = (state_s != IDLE);
  end

  assign tx      = tx_r;
  assign tx_busy = busy_r;

endmodule

// File: rtl/uart_txrx.sv
// 8N1 UART: independent transmitter and receiver sharing one bit-period parameter.
module uart_txrx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done
);

  uart_tx #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx),
    .tx_busy  (tx_busy)
  );

  uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_done (rx_done)
  );

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx: loopback frames, waveform shape, glitch, framing error, busy and reset.
module tb_uart_txrx;

  localparam int CPB   = 434;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, tx_busy, rx_done;
  logic [7:0] rx_data;
  logic       loop_en = 1'b1;
  logic       rx_drv = 1'b1;
  logic       rx_line;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int busy_cycles = 0;
  int busy_rises  = 0;
  logic busy_q = 1'b0;

  assign rx_line = loop_en ? tx : rx_drv;

  always #10 clk = ~clk;

  uart_txrx #(.CLK_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .rx       (rx_line),
    .rx_data  (rx_data),
    .rx_done  (rx_done)
  );

  // Event monitor sampled on the falling edge
  always @(negedge clk) begin
    if (rx_done) done_cnt <= done_cnt + 1;
    if (tx_busy) busy_cycles <= busy_cycles + 1;
    if (tx_busy && !busy_q) busy_rises <= busy_rises + 1;
    busy_q <= tx_busy;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (tx_busy && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (tx_busy) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Send one byte in loopback, compare the tx waveform cycle by cycle and the received byte
  task automatic tx_frame(input string tag, input logic [7:0] d, input int hold);
    int errs = 0;
    int b0, r0, d0, idx;
    logic exp_bit;
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    b0 = busy_cycles; r0 = busy_rises; d0 = done_cnt;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i == hold - 1) tx_start = 1'b0;
      idx = i / CPB;
      if (idx == 0) exp_bit = 1'b0;
      else if (idx == 9) exp_bit = 1'b1;
      else exp_bit = d[idx-1];
      if (tx !== exp_bit) errs++;
    end
    @(negedge clk);
    check_eq({tag, "_busy_end"}, {31'd0, tx_busy}, 32'd0);
    repeat (5) @(negedge clk);
    check_eq({tag, "_wave_errs"}, errs, 32'd0);
    check_eq({tag, "_busy_cycles"}, busy_cycles - b0, FRAME);
    check_eq({tag, "_frames"}, busy_rises - r0, 32'd1);
    check_eq({tag, "_done_cnt"}, done_cnt - d0, 32'd1);
    check_eq({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, d});
  endtask

  // Drive a frame on the external rx line with a chosen stop bit
  task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_drv = f[b];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin
    int d0, r0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_busy", {31'd0, tx_busy}, 32'd0);
    check_eq("rst_done", {31'd0, rx_done}, 32'd0);
    check_eq("rst_data", {24'd0, rx_data}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    tx_frame("a5", 8'hA5, 2);
    tx_frame("b01", 8'h01, 1);
    tx_frame("b80", 8'h80, 1);
    tx_frame("bff", 8'hFF, 1);
    tx_frame("b00", 8'h00, 1);

    // Glitch rejection, then a good externally driven frame
    loop_en = 1'b0;
    d0 = done_cnt;
    rx_drv = 1'b0;
    repeat (5) @(negedge clk);
    rx_drv = 1'b1;
    repeat (CPB) @(negedge clk);
    check_eq("glitch_done", done_cnt - d0, 32'd0);
    drive_frame(8'h3C, 1'b1);
    check_eq("glitch_next_done", done_cnt - d0, 32'd1);
    check_eq("glitch_next_data", {24'd0, rx_data}, 32'h3C);

    // Framing error keeps the old byte
    d0 = done_cnt;
    drive_frame(8'h55, 1'b0);
    check_eq("frm_err_done", done_cnt - d0, 32'd0);
    check_eq("frm_err_data", {24'd0, rx_data}, 32'h3C);
    drive_frame(8'hC3, 1'b1);
    check_eq("frm_next_done", done_cnt - d0, 32'd1);
    check_eq("frm_next_data", {24'd0, rx_data}, 32'hC3);

    // Busy handling and back-to-back acceptance
    loop_en = 1'b1;
    repeat (4) @(negedge clk);
    d0 = done_cnt; r0 = busy_rises;
    tx_data = 8'h11; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (2000) @(negedge clk);
    tx_data = 8'h22; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle("busy1");
    check_eq("busy_first_data", {24'd0, rx_data}, 32'h11);
    check_eq("busy_first_done", done_cnt - d0, 32'd1);
    tx_data = 8'h22; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check_eq("b2b_busy", {31'd0, tx_busy}, 32'd1);
    wait_idle("busy2");
    repeat (3) @(negedge clk);
    check_eq("b2b_data", {24'd0, rx_data}, 32'h22);
    check_eq("b2b_done", done_cnt - d0, 32'd2);
    check_eq("b2b_frames", busy_rises - r0, 32'd2);

    // Reset in the middle of data bit 3
    tx_data = 8'hF0; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (4 * CPB + 200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_tx", {31'd0, tx}, 32'd1);
    check_eq("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    check_eq("mid_rst_done", {31'd0, rx_done}, 32'd0);
    check_eq("mid_rst_data", {24'd0, rx_data}, 32'd0);
    repeat (4) @(negedge clk);
    tx_frame("r5a", 8'h5A, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
